// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, reset PC and instruction field positions.
package cpu_pkg;

  typedef enum logic [1:0] {
    StFetch   = 2'd0,
    StHold    = 2'd1,
    StDiscard = 2'd2
  } fetch_state_t;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

  localparam int unsigned OP_HI    = 15;
  localparam int unsigned OP_LO    = 13;
  localparam int unsigned FUNCT_HI = 3;
  localparam int unsigned FUNCT_LO = 0;

endpackage

// File: rtl/pcreg.sv
// Program counter register with load enable and asynchronous reset to RESET_PC.
module pcreg #(
  parameter int unsigned n        = 16,
  parameter logic [n-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [n-1:0] d,
  output logic [n-1:0] q
);

  // Hold pc unless a sequential step or redirect loads it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word-addressed memory requests, registers the
// returned instruction for decode, and handles stall, redirect and in-flight discard.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned  n        = 16,
  parameter logic [n-1:0] RESET_PC = n'(RESET_PC_DEFAULT)
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [n-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [n-1:0] imem_rdata,
  input  logic         stall,
  input  logic         redirect,
  input  logic [n-1:0] redirect_pc,
  output logic         instr_valid,
  output logic [n-1:0] instr,
  output logic [2:0]   op,
  output logic [3:0]   funct,
  output logic [n-1:0] pc_plus1,
  output logic [15:0]  fetch_count
);

  fetch_state_t state_q, state_d;
  logic [n-1:0] pc, pc_next, pc_inc;
  logic         pc_load;
  logic [n-1:0] addr_q, addr_d;
  logic [n-1:0] instr_d, pc_plus1_d;
  logic         valid_d;
  logic [15:0]  count_d;
  logic         can_accept;

  pcreg #(
    .n        (n),
    .RESET_PC (RESET_PC)
  ) u_pcreg (
    .clk   (clk),
    .reset (reset),
    .load  (pc_load),
    .d     (pc_next),
    .q     (pc)
  );

  assign pc_inc = pc + n'(1);
  assign op     = instr[OP_HI:OP_LO];
  assign funct  = instr[FUNCT_HI:FUNCT_LO];

  // A request in DISCARD must keep presenting the abandoned address until its ack.
  assign imem_addr = (state_q == StDiscard) ? addr_q : pc;

  // Request generation, next-state and datapath updates; redirect overrides everything.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    instr_d    = instr;
    valid_d    = instr_valid;
    pc_plus1_d = pc_plus1;
    count_d    = fetch_count;
    pc_load    = 1'b0;
    pc_next    = pc_inc;

    can_accept = !instr_valid || !stall;
    imem_req   = !reset && (((state_q == StFetch) && can_accept) || (state_q == StDiscard));

    unique case (state_q)
      StFetch:   if (!can_accept) state_d = StHold;
      StHold:    if (!stall) state_d = StFetch;
      StDiscard: if (imem_ack) state_d = StFetch;
      default:   state_d = StFetch;
    endcase

    if ((state_q == StFetch) && imem_req && imem_ack && !redirect) begin
      instr_d    = imem_rdata;
      valid_d    = 1'b1;
      pc_plus1_d = pc_inc;
      count_d    = fetch_count + 16'd1;
      pc_load    = 1'b1;
    end else if (instr_valid && !stall) begin
      valid_d = 1'b0;
    end

    if (redirect) begin
      pc_load = 1'b1;
      pc_next = redirect_pc;
      valid_d = 1'b0;
      if (imem_req && !imem_ack) begin
        state_d = StDiscard;
        // Latch the outstanding address only on first entry; later redirects keep it.
        if (state_q != StDiscard) addr_d = pc;
      end else begin
        state_d = StFetch;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StFetch;
      addr_q      <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      pc_plus1    <= '0;
      fetch_count <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      instr       <= instr_d;
      instr_valid <= valid_d;
      pc_plus1    <= pc_plus1_d;
      fetch_count <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic [15:0] instr;
  logic [2:0]  op;
  logic [3:0]  funct;
  logic [15:0] pc_plus1;
  logic [15:0] fetch_count;

  int total = 0;
  int bad   = 0;

  fetch_stage #(
    .n        (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .op          (op),
    .funct       (funct),
    .pc_plus1    (pc_plus1),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic [15:0] rd, input logic s,
                       input logic r, input logic [15:0] rpc);
    imem_ack    = a;
    imem_rdata  = rd;
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #3;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_count", 32'(fetch_count), 32'd0);
    chk("rst_pcp1", 32'(pc_plus1), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    step();
    step();
    reset = 1'b0;

    // First fetch at RESET_PC, acked immediately.
    drive(1'b1, 16'h2003, 1'b0, 1'b0, 16'h0);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", 32'(imem_addr), 32'h0000);
    step();

    // Stall three cycles with a full output register.
    drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    chk("lat_valid", 32'(instr_valid), 32'd1);
    chk("lat_instr", 32'(instr), 32'h2003);
    chk("stall_req0", 32'(imem_req), 32'd0);
    step();
    drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    chk("hold_req1", 32'(imem_req), 32'd0);
    chk("hold_instr1", 32'(instr), 32'h2003);
    step();
    drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    chk("hold_req2", 32'(imem_req), 32'd0);
    chk("hold_instr2", 32'(instr), 32'h2003);
    chk("hold_valid", 32'(instr_valid), 32'd1);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk("unstall_req", 32'(imem_req), 32'd0);
    step();

    // Back-to-back acks from address 1.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 16'h2003, 1'b0, 1'b0, 16'h0);
      chk("seq_req", 32'(imem_req), 32'd1);
      chk("seq_addr", 32'(imem_addr), 32'(i));
      chk("seq_count", 32'(fetch_count), 32'(i));
      if (i == 1) chk("consumed_valid", 32'(instr_valid), 32'd0);
      else        chk("seq_pcp1", 32'(pc_plus1), 32'(i));
      step();
    end
    chk("seq_op", 32'(op), 32'd1);
    chk("seq_funct", 32'(funct), 32'h3);
    chk("seq_count5", 32'(fetch_count), 32'd5);

    // Redirect while addr 5 is outstanding; ack arrives two cycles later.
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0040);
    chk("redir_addr", 32'(imem_addr), 32'h0005);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk("disc_req", 32'(imem_req), 32'd1);
    chk("disc_addr", 32'(imem_addr), 32'h0005);
    chk("disc_valid", 32'(instr_valid), 32'd0);
    step();
    drive(1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0);
    chk("disc_addr2", 32'(imem_addr), 32'h0005);
    step();
    drive(1'b1, 16'h1234, 1'b0, 1'b1, 16'h0010);
    chk("post_disc_addr", 32'(imem_addr), 32'h0040);
    chk("post_disc_count", 32'(fetch_count), 32'd5);
    chk("post_disc_valid", 32'(instr_valid), 32'd0);
    step();

    // Redirect coincided with ack: data dropped, fetch at target.
    drive(1'b1, 16'h5555, 1'b0, 1'b1, 16'hFFFF);
    chk("same_valid", 32'(instr_valid), 32'd0);
    chk("same_addr", 32'(imem_addr), 32'h0010);
    chk("same_req", 32'(imem_req), 32'd1);
    chk("same_count", 32'(fetch_count), 32'd5);
    step();

    // Wrap from 16'hFFFF.
    drive(1'b1, 16'hA5A1, 1'b0, 1'b0, 16'h0);
    chk("wrap_addr_ff", 32'(imem_addr), 32'hFFFF);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0100);
    chk("wrap_pcp1", 32'(pc_plus1), 32'h0000);
    chk("wrap_addr", 32'(imem_addr), 32'h0000);
    chk("wrap_instr", 32'(instr), 32'hA5A1);
    chk("wrap_op", 32'(op), 32'd5);
    chk("wrap_funct", 32'(funct), 32'h1);
    chk("wrap_count", 32'(fetch_count), 32'd6);
    step();

    // Second redirect inside DISCARD replaces the target only.
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0200);
    chk("dd_addr", 32'(imem_addr), 32'h0000);
    step();
    drive(1'b1, 16'h7777, 1'b0, 1'b0, 16'h0);
    chk("dd_addr2", 32'(imem_addr), 32'h0000);
    chk("dd_req", 32'(imem_req), 32'd1);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0300);
    chk("dd_target", 32'(imem_addr), 32'h0200);
    chk("dd_count", 32'(fetch_count), 32'd6);
    step();

    // Asynchronous reset in the middle of DISCARD.
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk("pre_rst_addr", 32'(imem_addr), 32'h0200);
    reset = 1'b1;
    #1;
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_count", 32'(fetch_count), 32'd0);
    chk("mid_rst_instr", 32'(instr), 32'd0);
    chk("mid_rst_pcp1", 32'(pc_plus1), 32'd0);
    chk("mid_rst_addr", 32'(imem_addr), 32'h0000);
    step();
    reset = 1'b0;
    drive(1'b1, 16'h2003, 1'b0, 1'b0, 16'h0);
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_addr", 32'(imem_addr), 32'h0000);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk("rel_valid", 32'(instr_valid), 32'd1);
    chk("rel_count", 32'(fetch_count), 32'd1);
    chk("rel_addr1", 32'(imem_addr), 32'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter n, default 16: datapath, address and instruction width.
REQ-002 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  instruction memory request; imem_addr valid while high.
REQ-006 imem_addr  output  n  word address of requested instruction.
REQ-007 imem_ack  input  1  memory returns imem_rdata this cycle; meaningful only while imem_req high.
REQ-008 imem_rdata  input  n  instruction word.
REQ-009 stall  input  1  downstream decode/controller cannot accept a new instruction.
REQ-010 redirect  input  1  taken branch or jump (pcsrc | jump from the controller).
REQ-011 redirect_pc  input  n  target address, sampled when redirect high.
REQ-012 instr_valid  output  1  instr/op/funct/pc_plus1 hold a valid instruction.
REQ-013 instr  output  n  registered instruction word.
REQ-014 op  output  3  instr[15:13], feeds controller op.
REQ-015 funct  output  4  instr[3:0], feeds controller funct.
REQ-016 pc_plus1  output  n  address of the held instruction plus 1.
REQ-017 fetch_count  output  16  count of instructions delivered (instr_valid set by an accepted ack).

Function
REQ-018 PC word-addressed; sequential fetch increments pc by 1, modulo 2^n (16'hFFFF wraps to 16'h0000).
REQ-019 States: FETCH (imem_req=1), HOLD (output full under stall, imem_req=0), DISCARD (imem_req=1, returned data dropped).
REQ-020 imem_addr SHALL equal pc and remain stable while imem_req high until imem_ack; ack in the first cycle of req is legal.
REQ-021 FETCH, ack, no redirect: instr<=imem_rdata, instr_valid<=1, pc_plus1<=pc+1, pc<=pc+1, fetch_count+=1 (wraps at 16 bits).
REQ-022 FETCH issues req only when output register can accept (!instr_valid | !stall); otherwise next state HOLD with req low.
REQ-023 HOLD: all outputs held; leaves to FETCH the cycle after stall falls; instr_valid stays 1 until a new instruction loads or a redirect flushes.
REQ-024 instr_valid with !stall and no new ack: instr_valid<=0 (consumed).
REQ-025 Redirect, any state: pc<=redirect_pc, instr_valid<=0 next cycle; redirect has priority over stall and ack.
REQ-026 Redirect while req high and no ack that cycle: next state DISCARD; old address held until ack.
REQ-027 DISCARD, ack: data dropped, fetch_count unchanged, next state FETCH at redirected pc.
REQ-028 Redirect in same cycle as ack: returned data dropped, next state FETCH at redirect_pc, no DISCARD.
REQ-029 Redirect during DISCARD: pc replaced by newest redirect_pc; stays DISCARD until outstanding ack.
REQ-030 Fetch latency: ack in cycle t makes instr_valid=1 in cycle t+1.

Reset
REQ-031 Asserting reset at any time, including mid-request or in DISCARD, SHALL immediately force: pc=RESET_PC, state=FETCH, instr=0, instr_valid=0, pc_plus1=0, fetch_count=0.
REQ-032 During reset imem_req=0; first request (imem_addr=RESET_PC) in first cycle after reset deasserts.
REQ-033 Outstanding acks arriving after reset are the memory's responsibility; fetch_stage treats an ack in FETCH as a new response.

Structure
REQ-034 Shared package cpu_pkg holds state enum fetch_state_t, RESET_PC default, and op/funct field bit positions (OP_HI=15, OP_LO=13, FUNCT_HI=3, FUNCT_LO=0).
REQ-035 One sub-module pcreg: n-bit register, async active-high reset to RESET_PC, load enable; holds pc.
REQ-036 op and funct are pure bit-slices of instr, no extra logic.

Verification
REQ-037 Reset release, memory acks every cycle with rdata=16'h2003 -> imem_addr 0,1,2,...; op=3'b001, funct=4'h3, fetch_count increments each cycle.
REQ-038 stall high 3 cycles after first instr -> HOLD, imem_req=0, instr unchanged 3 cycles; fetch of addr 1 resumes the cycle after stall falls.
REQ-039 Redirect to 16'h0040 while req at addr 5 unacked, ack 2 cycles later -> imem_addr stays 5 until ack, data dropped, next req addr 16'h0040, fetch_count unchanged.
REQ-040 Redirect to 16'h0010 same cycle as ack -> instr_valid=0 next cycle, next imem_addr 16'h0010.
REQ-041 pc=16'hFFFF, ack -> pc_plus1=16'h0000, next imem_addr 16'h0000.
REQ-042 Reset asserted mid-DISCARD -> outputs zero immediately, after release imem_addr=RESET_PC, state FETCH.
